// File: rtl/rr_chan_mux.sv
// rr_chan_mux: N-channel, W-bit registered multiplexer with valid/ready handshakes.
// A round-robin arbiter picks one requesting input channel per cycle. The winner's
// word and its channel index are captured in a one-entry output register.
//
// Optional feature macro: RR_CHAN_MUX_FORCE_SEL_EN
//   When defined, force_en_i/force_sel_i bypass arbitration and pin the grant to
//   min(force_sel_i, CHANNELS-1). The round-robin pointer does not advance while forced.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-high
//   force_en_i   (macro only) force the grant to force_sel_i
//   force_sel_i  (macro only) forced channel index, clamped to CHANNELS-1
//   in_data_i    channel c occupies bits [c*WIDTH +: WIDTH]
//   in_valid_i   per-channel request
//   in_ready_o   per-channel accept, one-hot or zero
//   out_data_o   registered selected word
//   out_chan_o   registered index of the channel that supplied out_data_o
//   out_valid_o  output register holds a word
//   out_ready_i  consumer accepts out_data_o this cycle
module rr_chan_mux #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 7,
   parameter int unsigned SEL_W    = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
`ifdef RR_CHAN_MUX_FORCE_SEL_EN
   input  logic                      force_en_i,
   input  logic [SEL_W-1:0]          force_sel_i,
`endif
   input  logic [CHANNELS*WIDTH-1:0] in_data_i,
   input  logic [CHANNELS-1:0]       in_valid_i,
   output logic [CHANNELS-1:0]       in_ready_o,
   output logic [WIDTH-1:0]          out_data_o,
   output logic [SEL_W-1:0]          out_chan_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic [SEL_W-1:0] rr_grant;
   logic             rr_req;
   logic [SEL_W-1:0] grant;
   logic             req;
   logic             forced;
   logic             load;

   // Indices past the last channel fold onto the last channel.
   function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
      if (32'(s) >= CHANNELS) return SEL_W'(CHANNELS - 1);
      return s;
   endfunction

   // Round-robin scan starting at ptr_q and wrapping at CHANNELS.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      rr_grant = '0;
      rr_req   = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!rr_req && in_valid_i[idx]) begin
            rr_grant = SEL_W'(idx);
            rr_req   = 1'b1;
         end
      end
   end

   always_comb begin
      grant  = clamp_sel(rr_grant);
      req    = rr_req;
      forced = 1'b0;
`ifdef RR_CHAN_MUX_FORCE_SEL_EN
      if (force_en_i) begin
         grant  = clamp_sel(force_sel_i);
         req    = in_valid_i[grant];
         forced = 1'b1;
      end
`endif
   end

   assign load = !out_valid_q || out_ready_i;

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      in_ready_o  = '0;
      if (load) begin
         out_valid_d = req;
         if (req) begin
            out_data_d = in_data_i[32'(grant)*WIDTH +: WIDTH];
            out_chan_d = grant;
            if (!forced) begin
               ptr_d = (32'(grant) == CHANNELS - 1) ? '0 : grant + SEL_W'(1);
            end
            // Gate with rst_i: reset clears out_valid, which would otherwise open load.
            if (!rst_i) in_ready_o = CHANNELS'(1) << grant;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data_o  = out_data_q;
   assign out_chan_o  = out_chan_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_rr_chan_mux.sv
// Directed testbench for rr_chan_mux with default parameters (WIDTH=8, CHANNELS=7).
module tb_rr_chan_mux;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned CHANNELS = 7;
   localparam int unsigned SEL_W    = 3;

   logic                      clk;
   logic                      rst;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_valid;
   logic                      out_ready;
`ifdef RR_CHAN_MUX_FORCE_SEL_EN
   logic                      force_en;
   logic [SEL_W-1:0]          force_sel;
`endif

   int checks = 0;
   int errors = 0;

   rr_chan_mux #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
`ifdef RR_CHAN_MUX_FORCE_SEL_EN
      .force_en_i  (force_en),
      .force_sel_i (force_sel),
`endif
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_chan_o  (out_chan),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input int ch, input logic [7:0] d);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
      chk({tag, "_data"}, 32'(out_data), 32'(d));
   endtask

   // Async reset pulse mid-cycle, held across one edge, released after the edge.
   task automatic pulse_reset();
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", 32'(out_data), 32'd0);
      chk("async_rst_ready", 32'(in_ready), 32'd0);
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int exp_ch;
      int seq4 [4];
      seq4 = '{2, 5, 2, 5};

      rst       = 1'b1;
      out_ready = 1'b1;
      in_valid  = '1;
      for (int c = 0; c < int'(CHANNELS); c++) in_data[c*WIDTH +: WIDTH] = 8'h10 + 8'(c);
`ifdef RR_CHAN_MUX_FORCE_SEL_EN
      force_en  = 1'b0;
      force_sel = '0;
`endif
      #2;

      // 1: reset held for 3 clocks with every channel requesting.
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("reset", 1'b0, 0, 8'h00);
         chk("reset_ready", 32'(in_ready), 32'd0);
      end
      rst = 1'b0;
      #1;

      // 2: all requesting, consumer always ready: 0..6 then wrap to 0.
      for (int i = 0; i < 8; i++) begin
         exp_ch = i % 7;
         chk("rr_ready", 32'(in_ready), 32'(1) << exp_ch);
         step();
         chk_out("rr", 1'b1, exp_ch, 8'h10 + 8'(exp_ch));
      end

      // 3: reach out_chan=2, then stall for 5 clocks.
      step();
      chk_out("pre_stall1", 1'b1, 1, 8'h11);
      step();
      chk_out("pre_stall2", 1'b1, 2, 8'h12);
      out_ready = 1'b0;
      #1;
      chk("stall_ready0", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out("stall", 1'b1, 2, 8'h12);
         chk("stall_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_ready", 32'(in_ready), 32'b0001000);
      step();
      chk_out("unstall", 1'b1, 3, 8'h13);

      // 6: async reset while holding a word; first grant afterwards restarts at ch0.
      pulse_reset();
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      step();
      chk_out("post_rst", 1'b1, 0, 8'h10);

      // 4: only channels 2 and 5 requesting, starting from ptr=0.
      pulse_reset();
      in_valid = 7'b0100100;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("sparse_ready", 32'(in_ready), 32'(1) << seq4[i]);
         chk("sparse_nogrant", 32'(in_ready & 7'b1011011), 32'd0);
         step();
         chk_out("sparse", 1'b1, seq4[i], 8'h10 + 8'(seq4[i]));
      end

      // No requests: register drains, data and channel hold.
      in_valid = '0;
      #1;
      chk("idle_ready", 32'(in_ready), 32'd0);
      step();
      chk_out("idle", 1'b0, 5, 8'h15);

`ifdef RR_CHAN_MUX_FORCE_SEL_EN
      // 5: forced selection of index 7 clamps to ch6; pointer stays at 0.
      pulse_reset();
      in_valid  = '1;
      force_en  = 1'b1;
      force_sel = 3'b111;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("force_ready", 32'(in_ready), 32'b1000000);
         step();
         chk_out("force", 1'b1, 6, 8'h16);
      end
      force_en = 1'b0;
      #1;
      chk("unforce_ready", 32'(in_ready), 32'd1);
      step();
      chk_out("unforce", 1'b1, 0, 8'h10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
